window_buffer: RTL and testbench
================================

WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 Parameter DATA_W, default 8, pixel bit width.
REQ-002 Parameter K, default 3, window edge; legal values 3 and 5 only.
REQ-003 Parameter MAX_WIDTH, default 640, line memory depth in pixels.
REQ-004 Parameters X_W, default 11, and Y_W, default 10, coordinate widths.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port clear  input  1  synchronous frame abort, active-high.
REQ-008 Port img_width  input  X_W  pixels per row; legal range K..MAX_WIDTH.
REQ-009 Port img_height  input  Y_W  rows per frame; legal minimum K.
REQ-010 Port stride  input  2  window stride; 1 or 2, other values treated as 1.
REQ-011 Port pixel_in  input  DATA_W  raster-order pixel.
REQ-012 Port pixel_valid  input  1  pixel_in valid.
REQ-013 Port pixel_ready  output  1  block accepts pixel this cycle.
REQ-014 Port win_out  output  K*K*DATA_W  window; element (r,c) at [(r*K+c)*DATA_W +: DATA_W], r=0 top row, c=0 left column.
REQ-015 Port win_valid  output  1  win_out, win_x, win_y valid.
REQ-016 Port win_ready  input  1  downstream accepts window.
REQ-017 Port win_x  output  X_W  top-left column of window.
REQ-018 Port win_y  output  Y_W  top-left row of window.
REQ-019 Port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-020 Pixel accepted when pixel_valid and pixel_ready both high in a cycle.
REQ-021 Internal counters x (0..img_width-1), y (0..img_height-1) advance per accepted pixel; x wraps to 0 and y increments at x=img_width-1.
REQ-022 img_width, img_height, stride latched when first pixel of a frame (x=0,y=0) is accepted; held constant for the frame.
REQ-023 K-1 line memories, depth MAX_WIDTH, DATA_W wide, hold the previous K-1 rows; plus K x K window shift register shifted left one column per accepted pixel.
REQ-024 Accepted pixel at (x,y) completes a window when x>=K-1 and y>=K-1 and (x-(K-1)) and (y-(K-1)) are both multiples of stride.
REQ-025 Completing window loaded into a one-deep output register; win_valid rises the cycle after acceptance (latency 1), win_x=x-(K-1), win_y=y-(K-1).
REQ-026 Window columns never span row boundaries: after x wraps, no window emitted until K new columns of the row are shifted in.
REQ-027 win_valid, win_out, win_x, win_y held stable while win_valid=1 and win_ready=0.
REQ-028 pixel_ready = (state RUN) and (win_valid=0 or win_ready=1); simultaneous window pop and push allowed in one cycle.
REQ-029 FSM states: RUN, DRAIN. RUN -> DRAIN on acceptance of pixel (img_width-1, img_height-1).
REQ-030 DRAIN: pixel_ready=0; when output register is empty (win_valid=0, or popped this cycle) frame_done pulses one cycle and state -> RUN with x=y=0.
REQ-031 No windows emitted for frames with img_width<K or img_height<K; frame_done still pulses after last pixel.
REQ-032 clear: x, y, window shift register, win_out, win_x, win_y, win_valid forced to 0, state -> RUN; line memory contents need not be cleared (never exposed per REQ-024).
REQ-033 Priority: reset > clear > normal operation; clear coincident with pixel acceptance discards the pixel.
REQ-034 Coordinate arithmetic unsigned, X_W/Y_W bits; no overflow within legal ranges.

Reset
REQ-035 On reset: state RUN, x=y=0, win_valid=0, win_out=0, win_x=0, win_y=0, frame_done=0, pixel_ready=1 the following cycle; latched config = input values.
REQ-036 Reset asserted mid-frame aborts the frame; next accepted pixel is (0,0) of a new frame, no partial window emitted.

Verification
REQ-037 K=3, 8x4, stride 1, pixels 1..32, win_ready=1 -> 12 windows; first window (0,0) = 1,2,3,9,10,11,17,18,19, win_valid one cycle after pixel 19; last window (5,1) ends in 32; frame_done one pulse.
REQ-038 Same frame, stride 2 -> exactly 3 windows at (0,0),(2,0),(4,0).
REQ-039 Same frame, win_ready low 5 cycles at first window -> win_out held at window (0,0), pixel_ready=0, no pixel lost; remaining 11 windows correct.
REQ-040 K=5, 6x5, stride 1 -> 2 windows at (0,0),(1,0); first window rows 1-5,7-11,13-17,19-23,25-29.
REQ-041 clear after 20 pixels -> next cycle win_valid=0, win_out=0; fresh 8x4 frame then produces REQ-037 output exactly.
REQ-042 Back-to-back frames with pixel_valid=1 continuous -> pixel_ready low only during DRAIN, frame_done once per frame, second frame windows identical to first.

Source files
------------

// File: rtl/window_buffer.sv
// Streaming KxK sliding-window generator for raster-order pixels.
// K-1 line memories feed a KxK shift register; completed windows land in a one-deep output register.
module window_buffer #(
    parameter int DATA_W    = 8,
    parameter int K         = 3,
    parameter int MAX_WIDTH = 640,
    parameter int X_W       = 11,
    parameter int Y_W       = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [X_W-1:0]          img_width,
    input  logic [Y_W-1:0]          img_height,
    input  logic [1:0]              stride,
    input  logic [DATA_W-1:0]       pixel_in,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    output logic [K*K*DATA_W-1:0]   win_out,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic [X_W-1:0]          win_x,
    output logic [Y_W-1:0]          win_y,
    output logic                    frame_done
);

    localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [X_W-1:0] KM1_X = X_W'(K - 1);
    localparam logic [Y_W-1:0] KM1_Y = Y_W'(K - 1);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t                 r_state;
    logic [X_W-1:0]         r_x;
    logic [Y_W-1:0]         r_y;
    logic [X_W-1:0]         r_width;
    logic [Y_W-1:0]         r_height;
    logic                   r_stride2;
    logic [DATA_W-1:0]      r_win  [K][K];
    logic [DATA_W-1:0]      r_line [K-1][MAX_WIDTH];

    logic [DATA_W-1:0]      w_col  [K];
    logic [DATA_W-1:0]      w_nwin [K][K];
    logic [K*K*DATA_W-1:0]  w_win_flat;
    logic                   w_accept;
    logic                   w_pop;
    logic                   w_first;
    logic                   w_fire;
    logic                   w_last_x;
    logic                   w_last_y;
    logic                   w_stride2;
    logic [X_W-1:0]         w_width;
    logic [Y_W-1:0]         w_height;
    logic [X_W-1:0]         w_dx;
    logic [Y_W-1:0]         w_dy;
    logic [ADDR_W-1:0]      w_addr;

    assign pixel_ready = (r_state == ST_RUN) && (!win_valid || win_ready);
    assign w_accept    = pixel_valid && pixel_ready;
    assign w_pop       = win_valid && win_ready;
    assign w_first     = (r_x == '0) && (r_y == '0);
    assign w_addr      = r_x[ADDR_W-1:0];
    assign w_dx        = r_x - KM1_X;
    assign w_dy        = r_y - KM1_Y;

    // The first pixel of a frame sees the configuration ports directly, later pixels the latched copy.
    always_comb begin
        if (w_first) begin
            w_width   = img_width;
            w_height  = img_height;
            w_stride2 = (stride == 2'd2);
        end else begin
            w_width   = r_width;
            w_height  = r_height;
            w_stride2 = r_stride2;
        end
    end

    assign w_last_x = (r_x == w_width - X_W'(1));
    assign w_last_y = (r_y == w_height - Y_W'(1));
    assign w_fire   = w_accept && (r_x >= KM1_X) && (r_y >= KM1_Y)
                      && (!w_stride2 || (!w_dx[0] && !w_dy[0]));

    // Next window: shift left one column, newest column is line memories (oldest row on top) plus pixel.
    always_comb begin
        w_col[K-1] = pixel_in;
        for (int r = 0; r < K - 1; r++) begin
            w_col[r] = r_line[K-2-r][w_addr];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                w_nwin[r][c] = r_win[r][c+1];
            end
            w_nwin[r][K-1] = w_col[r];
        end
        w_win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                w_win_flat[(r*K+c)*DATA_W +: DATA_W] = w_nwin[r][c];
            end
        end
    end

    // Line memories: row y-1 in memory 0, each accepted pixel ages its column by one row.
    always_ff @(posedge clk) begin
        if (w_accept && !reset && !clear) begin
            r_line[0][w_addr] <= pixel_in;
            for (int i = 1; i < K - 1; i++) begin
                r_line[i][w_addr] <= r_line[i-1][w_addr];
            end
        end
    end

    // Raster counters, window shift register, output register and RUN/DRAIN control.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_x        <= '0;
            r_y        <= '0;
            r_width    <= img_width;
            r_height   <= img_height;
            r_stride2  <= (stride == 2'd2);
            win_valid  <= 1'b0;
            win_out    <= '0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (clear) begin
            r_state    <= ST_RUN;
            r_x        <= '0;
            r_y        <= '0;
            win_valid  <= 1'b0;
            win_out    <= '0;
            win_x      <= '0;
            win_y      <= '0;
            frame_done <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= 1'b0;
            if (w_fire) begin
                win_out   <= w_win_flat;
                win_x     <= w_dx;
                win_y     <= w_dy;
                win_valid <= 1'b1;
            end else if (w_pop) begin
                win_valid <= 1'b0;
            end
            if (w_accept) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        r_win[r][c] <= w_nwin[r][c];
                    end
                end
                if (w_first) begin
                    r_width   <= img_width;
                    r_height  <= img_height;
                    r_stride2 <= (stride == 2'd2);
                end
                if (w_last_x) begin
                    r_x <= '0;
                    if (w_last_y) begin
                        r_y     <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_y <= r_y + Y_W'(1);
                    end
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            if ((r_state == ST_DRAIN) && (!win_valid || w_pop)) begin
                frame_done <= 1'b1;
                r_state    <= ST_RUN;
                r_x        <= '0;
                r_y        <= '0;
            end
        end
    end

endmodule

// File: tb/tb_window_buffer.sv
// Randomized bench for window_buffer: a frame-level model derives each expected window
// straight from the stored frame pixels and checks it against what the DUT pops out.
module tb_window_buffer;

    localparam int K  = 3;
    localparam int DW = 8;
    localparam int XW = 11;
    localparam int YW = 10;
    localparam int WW = K * K * DW;

    logic          clk = 1'b0;
    logic          reset, clear, pixel_valid, pixel_ready, win_valid, win_ready, frame_done;
    logic [XW-1:0] img_width, win_x;
    logic [YW-1:0] img_height, win_y;
    logic [1:0]    stride;
    logic [DW-1:0] pixel_in;
    logic [WW-1:0] win_out;

    logic          rst5, clr5, pv5, pr5, wv5, wr5, fd5;
    logic [XW-1:0] width5, wx5;
    logic [YW-1:0] height5, wy5;
    logic [1:0]    stride5;
    logic [DW-1:0] pin5;
    logic [199:0]  wo5;

    always #5 clk = ~clk;

    window_buffer #(.DATA_W(DW), .K(K), .MAX_WIDTH(640), .X_W(XW), .Y_W(YW)) u_dut (
        .clk(clk), .reset(reset), .clear(clear), .img_width(img_width), .img_height(img_height),
        .stride(stride), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready), .win_x(win_x),
        .win_y(win_y), .frame_done(frame_done));

    window_buffer #(.DATA_W(DW), .K(5), .MAX_WIDTH(640), .X_W(XW), .Y_W(YW)) u_dut5 (
        .clk(clk), .reset(rst5), .clear(clr5), .img_width(width5), .img_height(height5),
        .stride(stride5), .pixel_in(pin5), .pixel_valid(pv5), .pixel_ready(pr5),
        .win_out(wo5), .win_valid(wv5), .win_ready(wr5), .win_x(wx5),
        .win_y(wy5), .frame_done(fd5));

    typedef struct {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [WW-1:0] w;
    } win_t;

    win_t          exp_q[$];
    logic [DW-1:0] fm [64][64];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            pop_cnt  = 0;
    int            fd_cnt   = 0;
    logic          pend_acc = 1'b0, pend_fire = 1'b0, pend_last = 1'b0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: popped windows against the model queue, hold stability, frame_done pulses.
    logic          h_valid = 1'b0, prev_fd = 1'b0;
    logic [WW-1:0] h_out;
    logic [XW-1:0] h_x;
    logic [YW-1:0] h_y;
    always @(negedge clk) begin
        if (reset || clear) begin
            h_valid = 1'b0;
            prev_fd = 1'b0;
        end else begin
            if (h_valid) begin
                check_val("hold_valid", win_valid, 1'b1);
                check_val("hold_out", win_out, h_out);
                check_val("hold_xy", {win_x, win_y}, {h_x, h_y});
            end
            if (win_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_win", win_valid, 1'b0);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    check_val("win_out", win_out, e.w);
                    check_val("win_xy", {win_x, win_y}, {e.x, e.y});
                    pop_cnt++;
                end
            end
            h_valid = win_valid && !win_ready;
            h_out = win_out; h_x = win_x; h_y = win_y;
            if (frame_done) begin
                fd_cnt++;
                check_val("fd_pulse_width", prev_fd, 1'b0);
            end
            prev_fd = frame_done;
        end
    end

    // Per-cycle driver checks owed from the previous acceptance: latency-1 valid and DRAIN stall.
    task automatic drv_negedge();
        @(negedge clk);
        if (pend_acc)  check_val("lat_valid", win_valid, pend_fire);
        if (pend_last) check_val("drain_ready", pixel_ready, 1'b0);
        pend_acc = 1'b0; pend_fire = 1'b0; pend_last = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int s, input int vp, input int rp,
                              input bit seq, input int limit, input bit stall);
        int n = 0;
        int s_eff = (s == 2) ? 2 : 1;
        int stall_cnt = 0;
        int guard = 0;
        img_width = XW'(w); img_height = YW'(h); stride = 2'(s);
        while (n < limit && guard < 5000) begin
            bit acc;
            guard++;
            pixel_in    = seq ? DW'(n + 1) : DW'($urandom);
            pixel_valid = ($urandom_range(99) < vp);
            win_ready   = (stall && stall_cnt < 5) ? 1'b0 : ($urandom_range(99) < rp);
            drv_negedge();
            if (stall && stall_cnt < 5 && win_valid) begin
                check_val("stall_ready", pixel_ready, 1'b0);
                stall_cnt++;
            end
            acc = pixel_valid && pixel_ready;
            if (acc) begin
                int x = n % w;
                int y = n / w;
                fm[y][x] = pixel_in;
                pend_acc = 1'b1;
                if (x >= K-1 && y >= K-1 && (x-(K-1)) % s_eff == 0 && (y-(K-1)) % s_eff == 0) begin
                    win_t e;
                    e.x = XW'(x - (K-1));
                    e.y = YW'(y - (K-1));
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            e.w[(r*K+c)*DW +: DW] = fm[y-(K-1)+r][x-(K-1)+c];
                    exp_q.push_back(e);
                    pend_fire = 1'b1;
                end
                pend_last = (n == w*h - 1);
                n++;
            end
            @(posedge clk); #1;
            if (acc && n == 1) begin
                img_width = XW'(w + 1); img_height = YW'(h + 1); stride = (s == 2) ? 2'd1 : 2'd2;
            end
        end
        check_val("send_budget", n, limit);
    endtask

    task automatic wait_done(input int exp_cnt);
        pixel_valid = 1'b0;
        win_ready   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drv_negedge();
            #1;
            if (fd_cnt >= exp_cnt) break;
            @(posedge clk); #1;
        end
        check_val("frame_done_cnt", fd_cnt, exp_cnt);
        check_val("win_q_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic post_abort_checks(input string tag);
        @(negedge clk);
        check_val({tag, "_valid"}, win_valid, 1'b0);
        check_val({tag, "_out"}, win_out, '0);
        check_val({tag, "_xy"}, {win_x, win_y}, '0);
        check_val({tag, "_ready"}, pixel_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; pixel_valid = 1'b1; win_ready = 1'b1;
        drv_negedge();
        @(posedge clk); #1;
        clear = 1'b0; pixel_valid = 1'b0;
        exp_q.delete();
        post_abort_checks("clear");
    endtask

    task automatic do_reset();
        reset = 1'b1; pixel_valid = 1'b1;
        drv_negedge();
        @(posedge clk); #1;
        reset = 1'b0; pixel_valid = 1'b0;
        exp_q.delete();
        post_abort_checks("reset");
    endtask

    initial begin
        int c0, fd0;
        logic [199:0] k5w [2];
        logic [XW+YW-1:0] k5xy [2];
        logic [199:0] k5e;
        int acc5, nwin5, fdc5;

        reset = 1'b1; clear = 1'b0; pixel_valid = 1'b0; win_ready = 1'b1; pixel_in = '0;
        img_width = XW'(8); img_height = YW'(4); stride = 2'd1;
        rst5 = 1'b1; clr5 = 1'b0; pv5 = 1'b0; wr5 = 1'b1; pin5 = '0;
        width5 = XW'(6); height5 = YW'(5); stride5 = 2'd1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_valid", win_valid, 1'b0);
        check_val("rst_out", win_out, '0);
        check_val("rst_xy", {win_x, win_y}, '0);
        check_val("rst_fd", frame_done, 1'b0);
        check_val("rst_ready", pixel_ready, 1'b1);
        @(posedge clk); #1;

        c0 = pop_cnt; fd0 = fd_cnt;
        send_frame(8, 4, 1, 100, 100, 1'b1, 32, 1'b0);
        wait_done(fd0 + 1);
        check_val("s1_nwin", pop_cnt - c0, 12);

        c0 = pop_cnt; fd0 = fd_cnt;
        send_frame(8, 4, 2, 100, 100, 1'b1, 32, 1'b0);
        wait_done(fd0 + 1);
        check_val("s2_nwin", pop_cnt - c0, 3);

        c0 = pop_cnt; fd0 = fd_cnt;
        send_frame(8, 4, 1, 100, 100, 1'b1, 32, 1'b1);
        wait_done(fd0 + 1);
        check_val("stall_nwin", pop_cnt - c0, 12);

        send_frame(8, 4, 1, 100, 100, 1'b1, 20, 1'b0);
        do_clear();
        c0 = pop_cnt; fd0 = fd_cnt;
        send_frame(8, 4, 1, 100, 100, 1'b1, 32, 1'b0);
        wait_done(fd0 + 1);
        check_val("clr_nwin", pop_cnt - c0, 12);

        c0 = pop_cnt; fd0 = fd_cnt;
        send_frame(8, 4, 1, 100, 100, 1'b1, 32, 1'b0);
        send_frame(8, 4, 1, 100, 100, 1'b1, 32, 1'b0);
        wait_done(fd0 + 2);
        check_val("b2b_nwin", pop_cnt - c0, 24);

        c0 = pop_cnt; fd0 = fd_cnt;
        send_frame(2, 4, 1, 100, 100, 1'b0, 8, 1'b0);
        wait_done(fd0 + 1);
        check_val("narrow_nwin", pop_cnt - c0, 0);

        send_frame(8, 4, 1, 100, 100, 1'b0, 13, 1'b0);
        do_reset();

        for (int it = 0; it < 8; it++) begin
            int w = $urandom_range(3, 12);
            int h = $urandom_range(3, 6);
            fd0 = fd_cnt;
            send_frame(w, h, $urandom_range(0, 3), $urandom_range(50, 100),
                       $urandom_range(30, 100), 1'b0, w * h, 1'b0);
            wait_done(fd0 + 1);
        end

        // K=5 instance: 6x5 frame of 1..30 gives windows at (0,0) and (1,0).
        @(posedge clk); #1 rst5 = 1'b0;
        acc5 = 0; nwin5 = 0; fdc5 = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            pv5  = (acc5 < 30);
            pin5 = DW'(acc5 + 1);
            @(negedge clk);
            if (wv5 && wr5) begin
                if (nwin5 < 2) begin
                    k5w[nwin5]  = wo5;
                    k5xy[nwin5] = {wx5, wy5};
                end
                nwin5++;
            end
            if (fd5) fdc5++;
            if (pv5 && pr5) acc5++;
            @(posedge clk); #1;
        end
        check_val("k5_nwin", nwin5, 2);
        check_val("k5_fd", fdc5, 1);
        for (int i = 0; i < 2 && i < nwin5; i++) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    k5e[(r*5+c)*DW +: DW] = DW'(r*6 + c + 1 + i);
            check_val("k5_win", k5w[i], k5e);
            check_val("k5_xy", k5xy[i], {XW'(i), YW'(0)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
